systolic_array_4x4_ctrl: RTL and testbench

//  Sequencer for the 4x4 output-stationary systolic array. Accepts one 4-element activation vector
//  per beat over a valid/ready stream and applies the diagonal skew (row r delayed r cycles) onto
//  FDi0/4/8/12. Drives the north psum seeds RD0..RD3, waits for the wavefront to drain, then pulses

---
 rtl/systolic_array_4x4_ctrl_pkg.sv | 15 +
 rtl/systolic_array_4x4_ctrl_skew_delay_line.sv | 30 +++
 rtl/systolic_array_4x4_ctrl.sv | 182 ++++++++++++++++++
 tb/tb_systolic_array_4x4_ctrl.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/systolic_array_4x4_ctrl_pkg.sv
// Shared types and constants for the 4x4 systolic array sequencer.
package systolic_array_4x4_ctrl_pkg;

    localparam int unsigned SA_N     = 4;
    localparam int unsigned SKEW_MAX = SA_N - 1;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_FEED  = 3'd1,
        ST_DRAIN = 3'd2,
        ST_LOAD  = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

endpackage

// File: rtl/systolic_array_4x4_ctrl_skew_delay_line.sv
// DEPTH-stage shift register with asynchronous active-low clear; used for the row skew
// and for column seed timing.
module systolic_array_4x4_ctrl_skew_delay_line #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 1
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [WIDTH-1:0] i_d,
    output logic [WIDTH-1:0] o_q
);

    logic [WIDTH-1:0] r_stage [DEPTH];

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                r_stage[i] <= '0;
            end
        end else begin
            r_stage[0] <= i_d;
            for (int unsigned i = 1; i < DEPTH; i++) begin
                r_stage[i] <= r_stage[i-1];
            end
        end
    end

    assign o_q = r_stage[DEPTH-1];

endmodule

// File: rtl/systolic_array_4x4_ctrl.sv
// Job sequencer for the 4x4 output-stationary systolic array: skews activations, waits out the
// wavefront drain, strobes result_ld. Define SA_CTRL_BIAS_EN to seed the north psums from i_bias_data.
module systolic_array_4x4_ctrl
    import systolic_array_4x4_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned K_W          = 8,
    parameter int unsigned DRAIN_CYCLES = 7
) (
    input  logic                         i_clk,
    input  logic                         i_rst,      // asynchronous, active low
    input  logic                         i_start,
    input  logic [K_W-1:0]               i_k_len,
    input  logic                         i_act_valid,
    input  logic [SA_N*DATA_WIDTH-1:0]   i_act_data,
    output logic                         o_act_ready,
`ifdef SA_CTRL_BIAS_EN
    input  logic [SA_N*2*DATA_WIDTH-1:0] i_bias_data,
`endif
    output logic [DATA_WIDTH-1:0]        o_fdi0,
    output logic [DATA_WIDTH-1:0]        o_fdi4,
    output logic [DATA_WIDTH-1:0]        o_fdi8,
    output logic [DATA_WIDTH-1:0]        o_fdi12,
    output logic [2*DATA_WIDTH-1:0]      o_rd0,
    output logic [2*DATA_WIDTH-1:0]      o_rd1,
    output logic [2*DATA_WIDTH-1:0]      o_rd2,
    output logic [2*DATA_WIDTH-1:0]      o_rd3,
    output logic                         o_result_ld,
    output logic                         o_busy,
    output logic                         o_done
);

    localparam int unsigned PSUM_W    = 2 * DATA_WIDTH;
    localparam int unsigned DRAIN_LEN = DRAIN_CYCLES + SKEW_MAX;
    localparam int unsigned DRAIN_W   = $clog2(DRAIN_LEN + 1);

    state_e               r_state;
    logic [K_W-1:0]       r_k_len;
    logic [K_W-1:0]       r_beat_cnt;
    logic [DRAIN_W-1:0]   r_drain_cnt;
    logic                 r_act_ready;
    logic                 r_result_ld;
    logic                 r_busy;
    logic                 r_done;

    logic                 w_accept;
    logic                 w_last_beat;
    logic [DATA_WIDTH-1:0] w_row_in [SA_N];
    logic [DATA_WIDTH-1:0] w_fdi    [SA_N];
    logic [PSUM_W-1:0]     w_rd     [SA_N];

    assign w_accept    = i_act_valid & r_act_ready;
    assign w_last_beat = (r_beat_cnt == r_k_len - K_W'(1));

    // Job sequencing; outputs change on the same edges as the state.
    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_state     <= ST_IDLE;
            r_k_len     <= '0;
            r_beat_cnt  <= '0;
            r_drain_cnt <= '0;
            r_act_ready <= 1'b0;
            r_result_ld <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_result_ld <= 1'b0;
            r_done      <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (i_start) begin
                        r_k_len    <= i_k_len;
                        r_beat_cnt <= '0;
                        if (i_k_len != '0) begin
                            r_state     <= ST_FEED;
                            r_act_ready <= 1'b1;
                            r_busy      <= 1'b1;
                        end else begin
                            r_state <= ST_DONE;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_FEED: begin
                    if (w_accept) begin
                        if (w_last_beat) begin
                            r_state     <= ST_DRAIN;
                            r_act_ready <= 1'b0;
                            r_drain_cnt <= '0;
                        end else begin
                            r_beat_cnt <= r_beat_cnt + K_W'(1);
                        end
                    end
                end
                ST_DRAIN: begin
                    if (r_drain_cnt == DRAIN_W'(DRAIN_LEN - 1)) begin
                        r_state     <= ST_LOAD;
                        r_result_ld <= 1'b1;
                    end else begin
                        r_drain_cnt <= r_drain_cnt + DRAIN_W'(1);
                    end
                end
                ST_LOAD: begin
                    r_state <= ST_DONE;
                    r_busy  <= 1'b0;
                    r_done  <= 1'b1;
                end
                ST_DONE: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Row r sees r extra stages; non-accepted cycles inject zeros so the array never stalls.
    for (genvar r = 0; r < SA_N; r++) begin : g_row
        assign w_row_in[r] = w_accept ? i_act_data[DATA_WIDTH*r +: DATA_WIDTH] : '0;

        systolic_array_4x4_ctrl_skew_delay_line #(
            .WIDTH (DATA_WIDTH),
            .DEPTH (r + 1)
        ) u_skew (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_d   (w_row_in[r]),
            .o_q   (w_fdi[r])
        );
    end

`ifdef SA_CTRL_BIAS_EN
    logic [SA_N*PSUM_W-1:0] r_bias;
    logic                   w_first_beat;

    assign w_first_beat = w_accept & (r_beat_cnt == '0) & (r_state == ST_FEED);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            r_bias <= '0;
        end else if ((r_state == ST_IDLE) && i_start) begin
            r_bias <= i_bias_data;
        end
    end

    // Seed column j exactly when row 0's first beat reaches it.
    for (genvar j = 0; j < SA_N; j++) begin : g_seed
        logic [PSUM_W-1:0] w_seed_in;

        assign w_seed_in = w_first_beat ? r_bias[PSUM_W*j +: PSUM_W] : '0;

        systolic_array_4x4_ctrl_skew_delay_line #(
            .WIDTH (PSUM_W),
            .DEPTH (j + 1)
        ) u_seed (
            .i_clk (i_clk),
            .i_rst (i_rst),
            .i_d   (w_seed_in),
            .o_q   (w_rd[j])
        );
    end
`else
    for (genvar j = 0; j < SA_N; j++) begin : g_seed
        assign w_rd[j] = '0;
    end
`endif

    assign o_act_ready = r_act_ready;
    assign o_result_ld = r_result_ld;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_fdi0      = w_fdi[0];
    assign o_fdi4      = w_fdi[1];
    assign o_fdi8      = w_fdi[2];
    assign o_fdi12     = w_fdi[3];
    assign o_rd0       = w_rd[0];
    assign o_rd1       = w_rd[1];
    assign o_rd2       = w_rd[2];
    assign o_rd3       = w_rd[3];

endmodule

// File: tb/tb_systolic_array_4x4_ctrl.sv
// Scoreboard bench for systolic_array_4x4_ctrl; honours SA_CTRL_BIAS_EN when defined.
module tb_systolic_array_4x4_ctrl;

    logic          i_clk = 1'b0;
    logic          i_rst;
    logic          i_start;
    logic [7:0]    i_k_len;
    logic          i_act_valid;
    logic [63:0]   i_act_data;
    logic          o_act_ready;
    logic [127:0]  i_bias_data;
    logic [15:0]   o_fdi0, o_fdi4, o_fdi8, o_fdi12;
    logic [31:0]   o_rd0, o_rd1, o_rd2, o_rd3;
    logic          o_result_ld, o_busy, o_done;

    typedef struct packed {
        logic [31:0]       cyc;
        logic [3:0][15:0]  fdi;
        logic [3:0][31:0]  rd;
        logic              ld;
        logic              dn;
    } obs_t;

    obs_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   to_cnt   = 0;
    logic exp_ready = 1'b0;
    logic exp_busy  = 1'b0;
    logic end_req   = 1'b0;
    logic mon_done  = 1'b0;

    always #5 i_clk = ~i_clk;
    always @(posedge i_clk) cyc <= cyc + 1;

    systolic_array_4x4_ctrl dut (
        .i_clk       (i_clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_k_len     (i_k_len),
        .i_act_valid (i_act_valid),
        .i_act_data  (i_act_data),
        .o_act_ready (o_act_ready),
`ifdef SA_CTRL_BIAS_EN
        .i_bias_data (i_bias_data),
`endif
        .o_fdi0      (o_fdi0),
        .o_fdi4      (o_fdi4),
        .o_fdi8      (o_fdi8),
        .o_fdi12     (o_fdi12),
        .o_rd0       (o_rd0),
        .o_rd1       (o_rd1),
        .o_rd2       (o_rd2),
        .o_rd3       (o_rd3),
        .o_result_ld (o_result_ld),
        .o_busy      (o_busy),
        .o_done      (o_done)
    );

    // Monitor: owns all comparisons; pops the scoreboard whenever the DUT shows activity.
    always @(negedge i_clk) begin
        obs_t o;
        obs_t e;
        o.cyc = 32'(cyc);
        o.fdi = {o_fdi12, o_fdi8, o_fdi4, o_fdi0};
        o.rd  = {o_rd3, o_rd2, o_rd1, o_rd0};
        o.ld  = o_result_ld;
        o.dn  = o_done;
        if (end_req && !mon_done) begin
            checks++;
            if (sb_q.size() != 0) begin
                failures++;
                $display("FAIL sb_leftover got=%0d pending required=0", sb_q.size());
            end
            checks++;
            if (to_cnt != 0) begin
                failures++;
                $display("FAIL wait_bound got=%0d expirations required=0", to_cnt);
            end
            mon_done <= 1'b1;
        end else if (!i_rst) begin
            checks++;
            if (o.fdi !== '0 || o.rd !== '0 || o.ld !== 1'b0 || o.dn !== 1'b0 ||
                o_act_ready !== 1'b0 || o_busy !== 1'b0) begin
                failures++;
                $display("FAIL reset_zero cyc=%0d got fdi=%h rd=%h ld=%b done=%b rdy=%b busy=%b required all 0",
                         cyc, o.fdi, o.rd, o.ld, o.dn, o_act_ready, o_busy);
            end
        end else begin
            checks++;
            if (o_act_ready !== exp_ready || o_busy !== exp_busy) begin
                failures++;
                $display("FAIL ctrl cyc=%0d got rdy=%b busy=%b required rdy=%b busy=%b",
                         cyc, o_act_ready, o_busy, exp_ready, exp_busy);
            end
            if (o.fdi !== '0 || o.rd !== '0 || o.ld !== 1'b0 || o.dn !== 1'b0) begin
                checks++;
                if (sb_q.size() == 0) begin
                    failures++;
                    $display("FAIL unexpected_output cyc=%0d got fdi=%h rd=%h ld=%b done=%b required none",
                             cyc, o.fdi, o.rd, o.ld, o.dn);
                end else begin
                    e = sb_q.pop_front();
                    if (o !== e) begin
                        failures++;
                        $display("FAIL sb_event got cyc=%0d fdi=%h rd=%h ld=%b done=%b required cyc=%0d fdi=%h rd=%h ld=%b done=%b",
                                 o.cyc, o.fdi, o.rd, o.ld, o.dn, e.cyc, e.fdi, e.rd, e.ld, e.dn);
                    end
                end
            end
        end
    end

    function automatic logic vbit(input logic [31:0] vpat, input int i);
        return (i < 32) ? vpat[i] : 1'b1;
    endfunction

    // Beat b, row r carries (b+1) + 16*r: row 0 shows 1,2,3,..., row 3 shows 0x31,0x32,...
    function automatic logic [15:0] elem(input int b, input int r);
        return 16'((b + 1) + 16 * r);
    endfunction

    function automatic logic [63:0] beat(input int b);
        return {elem(b, 3), elem(b, 2), elem(b, 1), elem(b, 0)};
    endfunction

    // Expected output schedule for a job whose start is driven in cycle s.
    task automatic plan(input int s, input int k, input logic [31:0] vpat, input int cutoff);
        obs_t ev [64];
        int   acc [256];
        int   nb;
        int   c;
        int   last;
        for (int n = 0; n < 64; n++) begin
            ev[n]     = '0;
            ev[n].cyc = 32'(s + n);
        end
        nb = 0;
        c  = s + 1;
        while (nb < k) begin
            if (vbit(vpat, c - s - 1)) begin
                acc[nb] = c;
                nb++;
            end
            c++;
        end
        for (int b = 0; b < k; b++) begin
            for (int r = 0; r < 4; r++) begin
                ev[acc[b] + 1 + r - s].fdi[r] = elem(b, r);
            end
        end
        if (k > 0) begin
            last = acc[k-1];
            ev[last + 11 - s].ld = 1'b1;
            ev[last + 12 - s].dn = 1'b1;
`ifdef SA_CTRL_BIAS_EN
            for (int j = 0; j < 4; j++) begin
                ev[acc[0] + 1 + j - s].rd[j] = 32'(10 * (j + 1));
            end
`endif
        end else begin
            ev[1].dn = 1'b1;
        end
        for (int n = 0; n < 64; n++) begin
            if ((ev[n].fdi != '0 || ev[n].rd != '0 || ev[n].ld || ev[n].dn) && (s + n < cutoff)) begin
                sb_q.push_back(ev[n]);
            end
        end
    endtask

    // rst_beats >= 0 pulls reset after that many beats; sdrain pulses a second start mid-drain.
    task automatic run_job(input int k, input logic [31:0] vpat, input int rst_beats, input bit sdrain);
        int   s;
        int   b;
        int   i;
        int   last;
        logic v;
        @(posedge i_clk); #1;
        s       = cyc;
        i_start = 1'b1;
        i_k_len = 8'(k);
        plan(s, k, vpat, (rst_beats >= 0) ? (s + 1 + rst_beats) : (s + 1000));
        @(posedge i_clk); #1;
        i_start     = 1'b0;
        i_bias_data = {4{32'hDEAD_0000}};
        b = 0;
        i = 0;
        while (b < k && !(rst_beats >= 0 && b == rst_beats)) begin
            v           = vbit(vpat, i);
            exp_ready   = 1'b1;
            exp_busy    = 1'b1;
            i_act_valid = v;
            i_act_data  = v ? beat(b) : {4{16'hBEEF}};
            @(posedge i_clk); #1;
            if (v) b++;
            i++;
        end
        i_act_valid = 1'b1;
        i_act_data  = {4{16'hBEEF}};
        exp_ready   = 1'b0;
        if (rst_beats >= 0) begin
            i_rst    = 1'b0;
            exp_busy = 1'b0;
            repeat (3) @(posedge i_clk);
            #1;
            i_rst       = 1'b1;
            i_act_valid = 1'b0;
            repeat (8) @(posedge i_clk);
            #1;
        end else begin
            exp_busy = (k != 0);
            if (k != 0) begin
                last = cyc - 1;
                while (cyc < last + 12) begin
                    @(posedge i_clk); #1;
                    i_start = sdrain && (cyc == last + 3);
                    if (sdrain) i_k_len = 8'd2;
                end
                i_start  = 1'b0;
                exp_busy = 1'b0;
            end
            i_act_valid = 1'b0;
            for (int n = 0; n < 30 && sb_q.size() != 0; n++) begin
                @(posedge i_clk); #1;
            end
            if (sb_q.size() != 0) to_cnt++;
            repeat (4) @(posedge i_clk);
            #1;
        end
        i_bias_data = {32'd40, 32'd30, 32'd20, 32'd10};
    endtask

    initial begin
        i_rst       = 1'b0;
        i_start     = 1'b0;
        i_k_len     = 8'd0;
        i_act_valid = 1'b0;
        i_act_data  = '0;
        i_bias_data = {32'd40, 32'd30, 32'd20, 32'd10};
        repeat (3) @(posedge i_clk);
        #1;
        i_rst = 1'b1;
        repeat (2) @(posedge i_clk);

        run_job(4, 32'hFFFF_FFFF, -1, 1'b0);   // back-to-back beats
        run_job(3, 32'hFFFF_FFFD, -1, 1'b0);   // bubble in second FEED cycle
        run_job(0, 32'hFFFF_FFFF, -1, 1'b0);   // empty job
        run_job(4, 32'hFFFF_FFFF, -1, 1'b1);   // start ignored during drain
        run_job(2, 32'hFFFF_FFFE, -1, 1'b0);   // bubble before first beat
        run_job(8, 32'hFFFF_FFFF, 3, 1'b0);    // reset after 3 of 8 beats
        run_job(1, 32'hFFFF_FFFF, -1, 1'b0);   // recovery after reset

        end_req = 1'b1;
        for (int n = 0; n < 5 && !mon_done; n++) @(negedge i_clk);
        @(negedge i_clk);
        if (!mon_done) begin
            $display("FAIL monitor_end got=0 required=1");
            $fatal(1, "monitor did not finish");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
